// File: rtl/ahbl_gpio_port.sv
// ahbl_gpio_port
//   AHB-Lite responder for one general-purpose I/O port. It has per-pin
//   direction control and, optionally, rising-edge interrupts. Legal word
//   accesses complete with zero wait states. Unmapped offsets (>= 0x18) and
//   non-word sizes get a two-cycle ERROR response and change no state.
//
//   Register map (word offsets, all reset to 0):
//     0x00 DATA  R: synchronized GPIO_IN   W: GPIO_OUT register
//     0x04 DIR   RW, drives GPIO_OE (1 = drive)
//     0x08 IM    RW, interrupt mask
//     0x0C RIS   R,  raw rising-edge status
//     0x10 MIS   R,  RIS & IM
//     0x14 ICR   W,  write-1-to-clear RIS; reads 0
//
//   Optional feature macro: GPIO_IRQ_EN
//     defined   : edge detect, IM/RIS/MIS/ICR and IRQ are implemented.
//     undefined : 0x08..0x14 stay mapped (OKAY) but read 0 and ignore writes,
//                 IRQ is tied 0, and only the 2-flop synchronizer remains.
//
// Ports
//   HCLK, HRESET          bus clock; asynchronous active-high reset
//   HSEL, HADDR, HTRANS,  AHB-Lite address phase (only HADDR[7:2] decoded)
//   HWRITE, HSIZE, HREADY
//   HWDATA                write data, valid in the data phase
//   HREADYOUT, HRESP,     slave response to the splitter's multiplexer
//   HRDATA
//   GPIO_IN               asynchronous pad inputs
//   GPIO_OUT, GPIO_OE     pad output values and output enables
//   IRQ                   registered level interrupt, |(RIS & IM)

module ahbl_gpio_port #(
  parameter int WIDTH = 16
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             HSEL,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  input  logic             HWRITE,
  input  logic [2:0]       HSIZE,
  input  logic [31:0]      HWDATA,
  input  logic             HREADY,
  output logic             HREADYOUT,
  output logic             HRESP,
  output logic [31:0]      HRDATA,
  input  logic [WIDTH-1:0] GPIO_IN,
  output logic [WIDTH-1:0] GPIO_OUT,
  output logic [WIDTH-1:0] GPIO_OE,
  output logic             IRQ
);

  typedef enum logic [1:0] {
    RESP_IDLE,
    RESP_ERR1,
    RESP_ERR2
  } resp_state_e;

  typedef enum logic [2:0] {
    REG_DATA = 3'd0,
    REG_DIR  = 3'd1,
    REG_IM   = 3'd2,
    REG_RIS  = 3'd3,
    REG_MIS  = 3'd4,
    REG_ICR  = 3'd5
  } reg_sel_e;

  resp_state_e       state_q, state_d;
  logic              dp_valid_q, dp_valid_d;   // legal transfer in data phase
  logic              dp_write_q, dp_write_d;
  reg_sel_e          dp_sel_q, dp_sel_d;
  logic [WIDTH-1:0]  data_out_q, data_out_d;
  logic [WIDTH-1:0]  dir_q, dir_d;
  logic [WIDTH-1:0]  sync1_q, sync1_d;
  logic [WIDTH-1:0]  sync2_q, sync2_d;

  logic              addr_accept;
  logic              addr_legal;
  logic              wr_en;
  logic [31:0]       rdata;

  // Only a selected, active (NONSEQ/SEQ) transfer with the bus ready starts
  // a data phase; IDLE and BUSY are ignored.
  assign addr_accept = HSEL & HTRANS[1] & HREADY;
  assign addr_legal  = (HSIZE == 3'b010) && (HADDR[7:5] == 3'b000) &&
                       (HADDR[4:2] < 3'd6);
  // Illegal transfers never set dp_valid, so they cannot write anything.
  assign wr_en       = dp_valid_q & dp_write_q & HREADY;

  // ---------------------------------------------------------------------
  // Data-phase capture and response FSM
  // ---------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    dp_valid_d = dp_valid_q;
    dp_write_d = dp_write_q;
    dp_sel_d   = dp_sel_q;
    if (HREADY) begin
      dp_valid_d = addr_accept & addr_legal;
      dp_write_d = HWRITE;
      dp_sel_d   = reg_sel_e'(HADDR[4:2]);
    end
  end

  always_comb begin
    state_d   = state_q;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    unique case (state_q)
      RESP_IDLE: if (addr_accept && !addr_legal) state_d = RESP_ERR1;
      RESP_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_d   = RESP_ERR2;
      end
      RESP_ERR2: begin
        HRESP   = 1'b1;
        state_d = (addr_accept && !addr_legal) ? RESP_ERR1 : RESP_IDLE;
      end
      default: state_d = RESP_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Port registers and input synchronizer
  // ---------------------------------------------------------------------
  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    sync1_d    = GPIO_IN;
    sync2_d    = sync1_q;
    if (wr_en) begin
      case (dp_sel_q)
        REG_DATA: data_out_d = HWDATA[WIDTH-1:0];
        REG_DIR:  dir_d      = HWDATA[WIDTH-1:0];
        default:  ;
      endcase
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (HRESET) begin
      state_q    <= RESP_IDLE;
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_sel_q   <= REG_DATA;
      data_out_q <= '0;
      dir_q      <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
    end else begin
      state_q    <= state_d;
      dp_valid_q <= dp_valid_d;
      dp_write_q <= dp_write_d;
      dp_sel_q   <= dp_sel_d;
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
    end
  end

`ifdef GPIO_IRQ_EN
  // ---------------------------------------------------------------------
  // Edge detect, status and interrupt
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] im_q, im_d;
  logic [WIDTH-1:0] ris_q, ris_d;
  logic             irq_q, irq_d;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] icr_clr;

  assign rise    = sync2_q & ~prev_q;
  assign icr_clr = (wr_en && dp_sel_q == REG_ICR) ? HWDATA[WIDTH-1:0] : '0;

  always_comb begin
    prev_d = sync2_q;
    im_d   = (wr_en && dp_sel_q == REG_IM) ? HWDATA[WIDTH-1:0] : im_q;
    // A new edge in the same cycle as a clear keeps the bit set.
    ris_d  = (ris_q & ~icr_clr) | rise;
    irq_d  = |(ris_q & im_q);
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      prev_q <= '0;
      im_q   <= '0;
      ris_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      im_q   <= im_d;
      ris_q  <= ris_d;
      irq_q  <= irq_d;
    end
  end

  assign IRQ = irq_q;
`else
  assign IRQ = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Read data: driven only during a legal read data phase, else 0
  // ---------------------------------------------------------------------
  always_comb begin
    rdata = '0;
    if (dp_valid_q && !dp_write_q) begin
      case (dp_sel_q)
        REG_DATA: rdata[WIDTH-1:0] = sync2_q;
        REG_DIR:  rdata[WIDTH-1:0] = dir_q;
`ifdef GPIO_IRQ_EN
        REG_IM:   rdata[WIDTH-1:0] = im_q;
        REG_RIS:  rdata[WIDTH-1:0] = ris_q;
        REG_MIS:  rdata[WIDTH-1:0] = ris_q & im_q;
`endif
        default:  rdata = '0;
      endcase
    end
  end

  assign HRDATA   = rdata;
  assign GPIO_OUT = data_out_q;
  assign GPIO_OE  = dir_q;

  // Address bits outside the decoded window, the HTRANS SEQ/NONSEQ
  // distinction and write-data bits above the port width carry no meaning.
  logic unused_bus;
  assign unused_bus = ^{HADDR[31:8], HADDR[1:0], HTRANS[0]};

  if (WIDTH < 32) begin : g_hwdata_pad
    logic unused_hwdata;
    assign unused_hwdata = ^HWDATA[31:WIDTH];
  end

endmodule

// File: tb/tb_ahbl_gpio_port.sv
// tb_ahbl_gpio_port
//   Directed self-checking bench for ahbl_gpio_port (WIDTH = 16). The single
//   slave's HREADYOUT is looped back as the bus HREADY. Inputs change 1 ns
//   after a rising edge; outputs are sampled on the falling edge.

module tb_ahbl_gpio_port;

  localparam int W = 16;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [31:0]   HWDATA;
  logic          HREADY;
  logic          HREADYOUT;
  logic          HRESP;
  logic [31:0]   HRDATA;
  logic [W-1:0]  GPIO_IN;
  logic [W-1:0]  GPIO_OUT;
  logic [W-1:0]  GPIO_OE;
  logic          IRQ;

  int errors = 0;
  int checks = 0;

  always #5 HCLK = ~HCLK;
  assign HREADY = HREADYOUT;

  ahbl_gpio_port #(.WIDTH(W)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .HRDATA    (HRDATA),
    .GPIO_IN   (GPIO_IN),
    .GPIO_OUT  (GPIO_OUT),
    .GPIO_OE   (GPIO_OE),
    .IRQ       (IRQ)
  );

  // One complete non-pipelined transfer. Returns the HRESP seen in the first
  // data-phase cycle, the final HRESP/HRDATA, and the number of wait cycles
  // (bounded, so a stuck HREADYOUT shows up as a wrong wait count).
  task automatic xfer(input logic [31:0] addr, input logic wr,
                      input logic [2:0] size, input logic [31:0] wd,
                      output logic [31:0] rd, output logic resp_first,
                      output logic resp, output int waits);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr; HSIZE = size;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wd;
    waits = 0;
    @(negedge HCLK);
    resp_first = HRESP;
    while (!HREADYOUT && waits < 8) begin
      waits++;
      @(negedge HCLK);
    end
    rd   = HRDATA;
    resp = HRESP;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic        rf, rs;
    int          wt;
    HRESET = 1'b1;
    HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'b010; HWDATA = '0; GPIO_IN = '0;
    repeat (3) @(negedge HCLK);
    checks++; if (HREADYOUT !== 1'b1) begin errors++; $display("FAIL reset_hreadyout: got %b want 1", HREADYOUT); end
    checks++; if (HRESP !== 1'b0) begin errors++; $display("FAIL reset_hresp: got %b want 0", HRESP); end
    checks++; if (HRDATA !== 32'h0) begin errors++; $display("FAIL reset_hrdata: got %h want 0", HRDATA); end
    checks++; if (GPIO_OUT !== 16'h0) begin errors++; $display("FAIL reset_gpio_out: got %h want 0", GPIO_OUT); end
    checks++; if (GPIO_OE !== 16'h0) begin errors++; $display("FAIL reset_gpio_oe: got %h want 0", GPIO_OE); end
    checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", IRQ); end
    HRESET = 1'b0;
    for (int i = 0; i < 6; i++) begin
      xfer(32'(i * 4), 1'b0, 3'b010, 32'h0, rd, rf, rs, wt);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_read_%0h: got %h want 0", i * 4, rd); end
      checks++; if (rs !== 1'b0 || rf !== 1'b0) begin errors++; $display("FAIL reset_resp_%0h: got %b/%b want 0/0", i * 4, rf, rs); end
      checks++; if (wt != 0) begin errors++; $display("FAIL reset_waits_%0h: got %0d want 0", i * 4, wt); end
    end
  endtask

  task automatic test_write();
    logic [31:0] rd;
    logic        rf, rs;
    int          wt;
    xfer(32'h04, 1'b1, 3'b010, 32'h0000_00FF, rd, rf, rs, wt);
    checks++; if (rs !== 1'b0 || wt != 0) begin errors++; $display("FAIL write_dir_resp: got resp %b waits %0d want 0 0", rs, wt); end
    xfer(32'h00, 1'b1, 3'b010, 32'h0000_A5A5, rd, rf, rs, wt);
    xfer(32'h04, 1'b0, 3'b010, 32'h0, rd, rf, rs, wt);
    checks++; if (rd !== 32'h0000_00FF) begin errors++; $display("FAIL write_dir_read: got %h want 000000ff", rd); end
    checks++; if (GPIO_OE !== 16'h00FF) begin errors++; $display("FAIL write_gpio_oe: got %h want 00ff", GPIO_OE); end
    checks++; if (GPIO_OUT !== 16'hA5A5) begin errors++; $display("FAIL write_gpio_out: got %h want a5a5", GPIO_OUT); end
    xfer(32'h00, 1'b1, 3'b010, 32'hFFFF_FFFF, rd, rf, rs, wt);
    @(negedge HCLK);
    checks++; if (GPIO_OUT !== 16'hFFFF) begin errors++; $display("FAIL write_out_full: got %h want ffff", GPIO_OUT); end
    xfer(32'h04, 1'b1, 3'b010, 32'hFFFF_FFFF, rd, rf, rs, wt);
    xfer(32'h04, 1'b0, 3'b010, 32'h0, rd, rf, rs, wt);
    checks++; if (rd !== 32'h0000_FFFF) begin errors++; $display("FAIL write_upper_bits: got %h want 0000ffff", rd); end
    xfer(32'h04, 1'b1, 3'b010, 32'h0000_00FF, rd, rf, rs, wt);
  endtask

  // Pin change and a pipelined pair of DATA reads: the first data phase sees
  // the pin after one edge (not yet visible), the second after two edges.
  task automatic test_input_sync();
    @(posedge HCLK); #1;
    GPIO_IN = 16'h1234;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h00; HWRITE = 1'b0; HSIZE = 3'b010;
    @(posedge HCLK); #1;
    @(negedge HCLK);
    checks++; if (HRDATA !== 32'h0) begin errors++; $display("FAIL sync_early: got %h want 00000000", HRDATA); end
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    @(negedge HCLK);
    checks++; if (HRDATA !== 32'h0000_1234) begin errors++; $display("FAIL sync_data: got %h want 00001234", HRDATA); end
    checks++; if (HRESP !== 1'b0) begin errors++; $display("FAIL sync_resp: got %b want 0", HRESP); end
  endtask

`ifdef GPIO_IRQ_EN
  task automatic test_irq();
    logic [31:0] rd;
    logic        rf, rs;
    int          wt;
    xfer(32'h14, 1'b1, 3'b010, 32'h0000_FFFF, rd, rf, rs, wt);
    xfer(32'h08, 1'b1, 3'b010, 32'h0000_0001, rd, rf, rs, wt);
    xfer(32'h0C, 1'b0, 3'b010, 32'h0, rd, rf, rs, wt);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL irq_ris_cleared: got %h want 0", rd); end
    @(posedge HCLK); #1;
    GPIO_IN = 16'h1235;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL irq_edge3: got %b want 0", IRQ); end
    @(posedge HCLK);
    @(negedge HCLK);
    checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL irq_edge4: got %b want 1", IRQ); end
    xfer(32'h0C, 1'b0, 3'b010, 32'h0, rd, rf, rs, wt);
    checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL irq_ris: got %h want 00000001", rd); end
    xfer(32'h10, 1'b0, 3'b010, 32'h0, rd, rf, rs, wt);
    checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL irq_mis: got %h want 00000001", rd); end
    xfer(32'h14, 1'b1, 3'b010, 32'h0000_0001, rd, rf, rs, wt);
    xfer(32'h0C, 1'b0, 3'b010, 32'h0, rd, rf, rs, wt);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL irq_icr_clear: got %h want 0", rd); end
    checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL irq_after_clear: got %b want 0", IRQ); end
    xfer(32'h14, 1'b0, 3'b010, 32'h0, rd, rf, rs, wt);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL irq_icr_read: got %h want 0", rd); end
    // Fall back low, then time a rise so the edge lands with an ICR write.
    @(posedge HCLK); #1;
    GPIO_IN = 16'h1234;
    repeat (4) @(posedge HCLK);
    #1;
    GPIO_IN = 16'h1235;
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h14; HWRITE = 1'b1; HSIZE = 3'b010;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h0000_0001;
    xfer(32'h0C, 1'b0, 3'b010, 32'h0, rd, rf, rs, wt);
    checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL irq_set_wins: got %h want 00000001", rd); end
  endtask
`else
  task automatic test_irq_disabled();
    logic [31:0] rd;
    logic        rf, rs;
    int          wt;
    xfer(32'h08, 1'b1, 3'b010, 32'h0000_0001, rd, rf, rs, wt);
    checks++; if (rs !== 1'b0 || wt != 0) begin errors++; $display("FAIL noirq_im_write_resp: got resp %b waits %0d want 0 0", rs, wt); end
    xfer(32'h08, 1'b0, 3'b010, 32'h0, rd, rf, rs, wt);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL noirq_im_read: got %h want 0", rd); end
    checks++; if (rs !== 1'b0) begin errors++; $display("FAIL noirq_im_read_resp: got %b want 0", rs); end
    @(posedge HCLK); #1;
    GPIO_IN = 16'h1235;
    repeat (6) @(posedge HCLK);
    @(negedge HCLK);
    checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL noirq_irq: got %b want 0", IRQ); end
    for (int i = 3; i < 6; i++) begin
      xfer(32'(i * 4), 1'b0, 3'b010, 32'h0, rd, rf, rs, wt);
      checks++; if (rd !== 32'h0 || rs !== 1'b0) begin errors++; $display("FAIL noirq_read_%0h: got %h resp %b want 0 0", i * 4, rd, rs); end
    end
  endtask
`endif

  task automatic test_error();
    logic [31:0] rd;
    logic        rf, rs;
    int          wt;
    xfer(32'h18, 1'b0, 3'b010, 32'h0, rd, rf, rs, wt);
    checks++; if (wt != 1) begin errors++; $display("FAIL err_unmapped_waits: got %0d want 1", wt); end
    checks++; if (rf !== 1'b1 || rs !== 1'b1) begin errors++; $display("FAIL err_unmapped_resp: got %b/%b want 1/1", rf, rs); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err_unmapped_rdata: got %h want 0", rd); end
    xfer(32'h04, 1'b1, 3'b001, 32'h0000_1111, rd, rf, rs, wt);
    checks++; if (wt != 1 || rf !== 1'b1 || rs !== 1'b1) begin errors++; $display("FAIL err_halfword: got waits %0d resp %b/%b want 1 1/1", wt, rf, rs); end
    xfer(32'h04, 1'b0, 3'b010, 32'h0, rd, rf, rs, wt);
    checks++; if (rd !== 32'h0000_00FF) begin errors++; $display("FAIL err_dir_unchanged: got %h want 000000ff", rd); end
    checks++; if (GPIO_OE !== 16'h00FF) begin errors++; $display("FAIL err_oe_unchanged: got %h want 00ff", GPIO_OE); end
    // Illegal, illegal accepted in ERR2, then a legal read accepted in ERR2.
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h1C; HWRITE = 1'b0; HSIZE = 3'b010;
    @(posedge HCLK);
    @(negedge HCLK);
    checks++; if (HREADYOUT !== 1'b0 || HRESP !== 1'b1) begin errors++; $display("FAIL err_b2b_err1a: got ready %b resp %b want 0 1", HREADYOUT, HRESP); end
    @(posedge HCLK);
    @(negedge HCLK);
    checks++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b1) begin errors++; $display("FAIL err_b2b_err2a: got ready %b resp %b want 1 1", HREADYOUT, HRESP); end
    @(posedge HCLK); #1;
    HADDR = 32'h04;
    @(negedge HCLK);
    checks++; if (HREADYOUT !== 1'b0 || HRESP !== 1'b1) begin errors++; $display("FAIL err_b2b_err1b: got ready %b resp %b want 0 1", HREADYOUT, HRESP); end
    @(posedge HCLK);
    @(negedge HCLK);
    checks++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b1) begin errors++; $display("FAIL err_b2b_err2b: got ready %b resp %b want 1 1", HREADYOUT, HRESP); end
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    @(negedge HCLK);
    checks++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin errors++; $display("FAIL err_b2b_okay: got ready %b resp %b want 1 0", HREADYOUT, HRESP); end
    checks++; if (HRDATA !== 32'h0000_00FF) begin errors++; $display("FAIL err_b2b_rdata: got %h want 000000ff", HRDATA); end
  endtask

  // Write DIR and read it back in the very next (overlapping) transfer.
  task automatic test_back_to_back();
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h04; HWRITE = 1'b1; HSIZE = 3'b010;
    @(posedge HCLK); #1;
    HWDATA = 32'h0000_0F0F; HWRITE = 1'b0;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    @(negedge HCLK);
    checks++; if (HRDATA !== 32'h0000_0F0F) begin errors++; $display("FAIL b2b_read_new: got %h want 00000f0f", HRDATA); end
    checks++; if (GPIO_OE !== 16'h0F0F) begin errors++; $display("FAIL b2b_oe: got %h want 0f0f", GPIO_OE); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic        rf, rs;
    int          wt;
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h04; HWRITE = 1'b1; HSIZE = 3'b010;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h0000_00AA;
    #1 HRESET = 1'b1;
    #1;
    checks++; if (GPIO_OE !== 16'h0) begin errors++; $display("FAIL rstmid_oe: got %h want 0", GPIO_OE); end
    checks++; if (GPIO_OUT !== 16'h0) begin errors++; $display("FAIL rstmid_out: got %h want 0", GPIO_OUT); end
    checks++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 32'h0) begin errors++; $display("FAIL rstmid_bus: got ready %b resp %b rdata %h want 1 0 0", HREADYOUT, HRESP, HRDATA); end
    @(posedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    xfer(32'h04, 1'b0, 3'b010, 32'h0, rd, rf, rs, wt);
    checks++; if (rd !== 32'h0 || rs !== 1'b0) begin errors++; $display("FAIL rstmid_dir: got %h resp %b want 0 0", rd, rs); end
    checks++; if (GPIO_OE !== 16'h0) begin errors++; $display("FAIL rstmid_oe_after: got %h want 0", GPIO_OE); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_input_sync();
`ifdef GPIO_IRQ_EN
    test_irq();
`else
    test_irq_disabled();
`endif
    test_error();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ahbl_gpio_port.md
# ahbl_gpio_port

AHB-Lite responder for one general-purpose I/O port with per-pin direction control and rising-edge interrupts. Sits behind the peripheral-bus address splitter and takes one of its per-slave select lines; returns HRDATA/HREADYOUT/HRESP to the splitter's response multiplexer. Zero-wait-state for legal word accesses. Two-cycle ERROR response for unmapped offsets and non-word sizes.

## Interface
- WIDTH, 16, number of GPIO pins (1..32)
- HCLK  input  1  bus clock; all state on rising edge
- HRESET  input  1  asynchronous, active-high reset
- HSEL  input  1  slave select from the splitter
- HADDR  input  32  byte address; only HADDR[7:2] decoded
- HTRANS  input  2  transfer type; HTRANS[1]=1 means NONSEQ/SEQ
- HWRITE  input  1  1=write
- HSIZE  input  3  transfer size; only 3'b010 (word) legal
- HWDATA  input  32  write data, valid in the data phase
- HREADY  input  1  bus-wide ready (the splitter's muxed HREADY)
- HREADYOUT  output  1  this slave's ready
- HRESP  output  1  0=OKAY, 1=ERROR
- HRDATA  output  32  read data, valid in the data phase
- GPIO_IN  input  WIDTH  pad inputs, asynchronous
- GPIO_OUT  output  WIDTH  pad output values
- GPIO_OE  output  WIDTH  pad output enables, 1=drive
- IRQ  output  1  level interrupt, OR of masked status

## Operation
- Address phase accepted when HSEL & HTRANS[1] & HREADY; registers offset, HWRITE, legality. Otherwise no data phase follows (IDLE/BUSY ignored).
- Register map (offset, access, reset 0): 0x00 DATA (R: synchronized GPIO_IN; W: GPIO_OUT register); 0x04 DIR (RW, drives GPIO_OE); 0x08 IM (RW, interrupt mask); 0x0C RIS (R, raw edge status); 0x10 MIS (R, RIS & IM); 0x14 ICR (W, write-1-to-clear RIS; reads 0).
- Upper 32-WIDTH bits: read 0, write ignored.
- Illegal transfer: offset >= 0x18 or HSIZE != 3'b010. No register changes; ERROR response.
- Response FSM states:
  - IDLE: HREADYOUT=1, HRESP=0.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
  - Transitions: IDLE->ERR1 on accepting an illegal transfer; ERR1->ERR2 always; ERR2->ERR1 if another illegal transfer is accepted in ERR2, else IDLE.
- Input path: 2-flop synchronizer, then a third flop for edge detect. RIS[i] sets when sync[i]=1 and prev[i]=0.
- RIS set and ICR clear of the same bit in the same cycle: set wins.
- IRQ = |(RIS & IM), registered.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, GPIO_OUT=0, GPIO_OE=0, IRQ=0, all registers 0, FSM=IDLE.
- Legal read: HRDATA valid in the data phase (the cycle after acceptance), zero wait states. HRDATA=0 outside a read data phase and during ERROR.
- Legal write: register updates on the HCLK edge ending the data phase. A read of the same register in the next transfer returns the new value.
- Pin to DATA: a GPIO_IN change is readable 2 HCLK edges later. The RIS bit sets on the 3rd edge. IRQ asserts on the 4th edge.
- Back-to-back transfers are pipelined: the address phase of N+1 overlaps the data phase of N.
- HRESET asserted mid-transfer: all outputs return to reset values immediately. A pending write is discarded.

## Configuration
- GPIO_IRQ_EN defined: edge detect, IM/RIS/MIS/ICR and IRQ are implemented as above.
- GPIO_IRQ_EN undefined:
  - Offsets 0x08–0x14 stay mapped (OKAY response); they read 0 and ignore writes.
  - IRQ tied 0.
  - Only the 2-flop synchronizer remains.

## Test plan
- Reset, then read all six offsets -> all return 0x00000000 with HRESP=0, HREADYOUT=1; GPIO_OUT=0, GPIO_OE=0.
- Write DIR=0x00FF, then DATA=0xA5A5; read DIR -> 0x000000FF; GPIO_OE=0x00FF, GPIO_OUT=0xA5A5. Write 0xFFFFFFFF to DATA -> GPIO_OUT=0xFFFF, readback of upper bits 0.
- Drive GPIO_IN=0x1234 -> read DATA returns 0x00001234 no earlier than 2 cycles after the change.
- IM=0x0001; GPIO_IN[0] 0->1 -> RIS=0x0001, MIS=0x0001, IRQ=1 four edges later. Write ICR=0x0001 -> RIS=0, IRQ=0. Edge coinciding with the ICR write -> RIS stays 1.
- Read offset 0x18 -> HREADYOUT 0 then 1 with HRESP=1 for both cycles, no state change. Then a halfword (HSIZE=3'b001) write to DIR -> ERROR, DIR unchanged. Back-to-back legal read afterwards -> OKAY.
- Assert HRESET during a DIR write data phase -> DIR=0, GPIO_OE=0, FSM IDLE. With GPIO_IRQ_EN undefined, the IM write/read returns 0 and IRQ stays 0.
